// File: rtl/mulmod3329_if.sv
// Handshake and data bundle for the sequential multiply-mod-3329 unit.
// Optional op_cnt_o is present only when MULMOD3329_OPCNT_EN is defined.
interface mulmod3329_if;
    logic        start_i;
    logic [11:0] a_i;
    logic [11:0] b_i;
    logic        busy_o;
    logic        done_o;
    logic [11:0] r_o;
`ifdef MULMOD3329_OPCNT_EN
    logic [15:0] op_cnt_o;
`endif

    modport master (
        output start_i, a_i, b_i,
        input  busy_o, done_o, r_o
`ifdef MULMOD3329_OPCNT_EN
        , input op_cnt_o
`endif
    );

    modport slave (
        input  start_i, a_i, b_i,
        output busy_o, done_o, r_o
`ifdef MULMOD3329_OPCNT_EN
        , output op_cnt_o
`endif
    );
endinterface

// File: rtl/mulmod3329_seq.sv
// Sequential (a*b) mod 3329: shift-add multiply, Barrett-style quotient estimate,
// two fixed correction steps. Optional completed-op counter via MULMOD3329_OPCNT_EN.
module mulmod3329_seq (
    input  logic         clk_i,
    input  logic         rst_i,
    mulmod3329_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, MUL, QEST, SUB, CORR1, CORR2, DONE} state_t;

    localparam logic [13:0] MODQ = 14'd3329;

    state_t      state;
    logic [23:0] a_sh;
    logic [11:0] b_sh;
    logic [23:0] prod;
    logic [3:0]  cnt;
    logic [12:0] qh;
    logic [13:0] rem;
    logic        busy;
    logic        done;
    logic [11:0] r;
`ifdef MULMOD3329_OPCNT_EN
    logic [15:0] op_cnt;
`endif

    logic [12:0] qest;
    logic [13:0] rem_sub;
    logic [13:0] corr;

    // qh never exceeds the true quotient, so P - qh*3329 is non-negative and below 3*3329
    assign qest    = 13'(({13'd0, prod} * 37'd5039) >> 24);
    assign rem_sub = 14'(prod - 24'(qh) * 24'd3329);
    assign corr    = (rem >= MODQ) ? rem - MODQ : rem;

    assign bus.busy_o = busy;
    assign bus.done_o = done;
    assign bus.r_o    = r;
`ifdef MULMOD3329_OPCNT_EN
    assign bus.op_cnt_o = op_cnt;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            prod  <= '0;
            cnt   <= '0;
            qh    <= '0;
            rem   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            r     <= '0;
`ifdef MULMOD3329_OPCNT_EN
            op_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        a_sh  <= {12'd0, bus.a_i};
                        b_sh  <= bus.b_i;
                        prod  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= MUL;
                    end
                end
                MUL: begin
                    prod <= prod + (b_sh[0] ? a_sh : 24'd0);
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 4'd1;
                    if (cnt == 4'd11) begin
                        state <= QEST;
                    end
                end
                QEST: begin
                    qh    <= qest;
                    state <= SUB;
                end
                SUB: begin
                    rem   <= rem_sub;
                    state <= CORR1;
                end
                CORR1: begin
                    rem   <= corr;
                    state <= CORR2;
                end
                // Result and done are registered together so r_o is valid for the whole pulse
                CORR2: begin
                    rem   <= corr;
                    r     <= corr[11:0];
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef MULMOD3329_OPCNT_EN
                    op_cnt <= op_cnt + 16'd1;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mulmod3329_seq.sv
// Directed bench for mulmod3329_seq: reset, vectors, latency, ignored starts,
// mid-operation reset, continuous start and an operand sweep.
module tb_mulmod3329_seq;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   done_seen;

    mulmod3329_if bus ();

    mulmod3329_seq dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent count of done pulses, used to cross-check the optional counter
    always @(negedge clk) begin
        if (rst) done_seen <= 0;
        else if (bus.done_o === 1'b1) done_seen <= done_seen + 1;
    end

    // Called at a falling edge; start is sampled on the next rising edge.
    // lat is the number of falling edges until done_o is seen, -1 on timeout.
    task automatic run_op(input logic [11:0] a, input logic [11:0] b,
                          output logic [11:0] r, output int lat);
        bus.a_i     = a;
        bus.b_i     = b;
        bus.start_i = 1'b1;
        lat = -1;
        r   = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) bus.start_i = 1'b0;
            if (bus.done_o === 1'b1) begin
                lat = i;
                r   = bus.r_o;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        #12;
        checks++;
        if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy_o); end
        checks++;
        if (bus.done_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", bus.done_o); end
        checks++;
        if (bus.r_o !== 12'd0) begin failures++; $display("[TB] FAIL reset_r got=%0d exp=0", bus.r_o); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic [11:0] va [10] = '{12'd3328, 12'd4095, 12'd17,   12'd0,    12'd4095,
                                 12'd3329, 12'd1,    12'd1234, 12'd4095, 12'd2000};
        logic [11:0] vb [10] = '{12'd3328, 12'd4095, 12'd1000, 12'd4095, 12'd0,
                                 12'd5,    12'd1,    12'd2345, 12'd1,    12'd2000};
        logic [11:0] ve [10] = '{12'd1,    12'd852,  12'd355,  12'd0,    12'd0,
                                 12'd0,    12'd1,    12'd829,  12'd766,  12'd1871};
        logic [11:0] r;
        int lat;
        for (int i = 0; i < 10; i++) begin
            run_op(va[i], vb[i], r, lat);
            checks++;
            if (lat != 17) begin failures++; $display("[TB] FAIL vec%0d_latency got=%0d exp=17", i, lat); end
            checks++;
            if (r !== ve[i]) begin failures++; $display("[TB] FAIL vec%0d_result a=%0d b=%0d got=%0d exp=%0d", i, va[i], vb[i], r, ve[i]); end
        end
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        int done_at = -1;
        logic [11:0] r = '0;
        logic busy17 = 1'b0;
        logic busy18 = 1'b1;
        bus.a_i = 12'd17; bus.b_i = 12'd1000; bus.start_i = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) bus.start_i = 1'b0;
            if (i == 5) begin bus.start_i = 1'b1; bus.a_i = 12'd4095; bus.b_i = 12'd4095; end
            if (i == 6) bus.start_i = 1'b0;
            if (i == 17) busy17 = bus.busy_o;
            if (i == 18) busy18 = bus.busy_o;
            if (bus.done_o === 1'b1) begin pulses++; done_at = i; r = bus.r_o; end
        end
        checks++;
        if (pulses != 1) begin failures++; $display("[TB] FAIL ignore_pulses got=%0d exp=1", pulses); end
        checks++;
        if (done_at != 17) begin failures++; $display("[TB] FAIL ignore_done_at got=%0d exp=17", done_at); end
        checks++;
        if (r !== 12'd355) begin failures++; $display("[TB] FAIL ignore_result got=%0d exp=355", r); end
        checks++;
        if (busy17 !== 1'b1) begin failures++; $display("[TB] FAIL ignore_busy17 got=%b exp=1", busy17); end
        checks++;
        if (busy18 !== 1'b0) begin failures++; $display("[TB] FAIL ignore_busy18 got=%b exp=0", busy18); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        logic [11:0] r;
        int lat;
        bus.a_i = 12'd1234; bus.b_i = 12'd2345; bus.start_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) bus.start_i = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%b exp=0", bus.busy_o); end
        checks++;
        if (bus.done_o !== 1'b0) begin failures++; $display("[TB] FAIL midrst_done got=%b exp=0", bus.done_o); end
        checks++;
        if (bus.r_o !== 12'd0) begin failures++; $display("[TB] FAIL midrst_r got=%0d exp=0", bus.r_o); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("[TB] FAIL midrst_pulses got=%0d exp=0", pulses); end
        run_op(12'd2000, 12'd2000, r, lat);
        checks++;
        if (r !== 12'd1871 || lat != 17) begin failures++; $display("[TB] FAIL midrst_after got=%0d lat=%0d exp=1871 lat=17", r, lat); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int at [4];
        int bad_r = 0;
        bus.a_i = 12'd17; bus.b_i = 12'd1000; bus.start_i = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                if (pulses < 4) at[pulses] = i;
                pulses++;
                if (bus.r_o !== 12'd355) bad_r++;
            end
        end
        bus.start_i = 1'b0;
        checks++;
        if (pulses != 3) begin failures++; $display("[TB] FAIL b2b_pulses got=%0d exp=3", pulses); end
        else begin
            checks++;
            if (at[0] != 17 || at[1] != 35 || at[2] != 53) begin
                failures++; $display("[TB] FAIL b2b_spacing got=%0d,%0d,%0d exp=17,35,53", at[0], at[1], at[2]);
            end
        end
        checks++;
        if (bad_r != 0) begin failures++; $display("[TB] FAIL b2b_result bad=%0d exp=0", bad_r); end
        for (int i = 0; i < 30 && bus.busy_o === 1'b1; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drain got=%b exp=0", bus.busy_o); end
    endtask

    task automatic test_sweep();
        logic [11:0] r;
        logic [11:0] a;
        logic [11:0] b;
        int lat;
        int exp_r;
        for (int ai = 0; ai < 4096; ai += 5) begin
            a = 12'(ai);
            exp_r = (ai * 4095) % 3329;
            run_op(a, 12'd4095, r, lat);
            checks++;
            if (r !== 12'(exp_r) || lat != 17) begin
                failures++; $display("[TB] FAIL sweep a=%0d b=4095 got=%0d lat=%0d exp=%0d", ai, r, lat, exp_r);
            end
        end
        for (int k = 0; k < 200; k++) begin
            a = 12'($urandom_range(4095));
            b = 12'($urandom_range(4095));
            exp_r = (int'(a) * int'(b)) % 3329;
            run_op(a, b, r, lat);
            checks++;
            if (r !== 12'(exp_r) || lat != 17) begin
                failures++; $display("[TB] FAIL random a=%0d b=%0d got=%0d lat=%0d exp=%0d", a, b, r, lat, exp_r);
            end
        end
    endtask

    task automatic test_opcnt();
`ifdef MULMOD3329_OPCNT_EN
        checks++;
        if (bus.op_cnt_o !== 16'(done_seen)) begin
            failures++; $display("[TB] FAIL opcnt got=%0d exp=%0d", bus.op_cnt_o, done_seen);
        end
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_vectors();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        test_opcnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mulmod3329_seq.md
MULMOD3329_SEQ -- requirements
Module: mulmod3329_seq

Interface
REQ-001 SHALL: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: rst_i  input  1  reset, asynchronous and active-high.
REQ-003 SHALL: start_i  input  1  request; sampled only in IDLE; a 1-cycle pulse is sufficient.
REQ-004 SHALL: a_i  input  12  operand A, unsigned, 0..4095; need not be reduced.
REQ-005 SHALL: b_i  input  12  operand B, unsigned, 0..4095; need not be reduced.
REQ-006 SHALL: busy_o  output  1  high from the cycle after acceptance until done_o falls.
REQ-007 SHALL: done_o  output  1  one-cycle pulse marking r_o valid.
REQ-008 SHALL: r_o  output  12  (a_i*b_i) mod 3329, range 0..3328; held until the next acceptance.
REQ-009 SHALL: op_cnt_o  output  16  count of completed operations; present only with MULMOD3329_OPCNT_EN.

Function
REQ-010 SHALL: FSM states IDLE, MUL, QEST, SUB, CORR1, CORR2, DONE.
REQ-011 SHALL: IDLE -> MUL when start_i=1; a_i and b_i are captured into internal registers on that edge.
REQ-012 SHALL: MUL is a 12-cycle shift-add loop on B bits, LSB first, with a 4-bit counter; it forms the 24-bit product P = A*B exactly.
REQ-013 SHALL: MUL -> QEST when the counter reaches 11.
REQ-014 SHALL: QEST computes qh = floor(P*5039 / 2^24), where 5039 = floor(2^24/3329); the intermediate is 37 bits and qh is 13 bits.
REQ-015 SHALL: SUB computes R = P - qh*3329 in 14 bits; R is guaranteed to lie in 0..3*3329-1.
REQ-016 SHALL: CORR1 and CORR2 each perform R = R-3329 if R >= 3329, else leave R unchanged; the compare is >=, not >.
REQ-017 SHALL: both correction states always execute, giving a fixed, data-independent latency.
REQ-018 SHALL: DONE drives r_o = R[11:0] and done_o=1 for exactly one cycle, then returns to IDLE.
REQ-019 SHALL: latency is fixed: done_o is high in the 17th cycle after the edge that samples start_i.
REQ-020 SHALL: back-to-back throughput is one operation per 18 cycles (start_i may be high in the cycle done_o falls).
REQ-021 SHALL: start_i while busy_o=1 is ignored, with no queuing and no effect on the operation in flight.
REQ-022 SHALL: operand changes while busy do not affect the result.
REQ-023 SHALL: start_i held high continuously re-triggers a new operation on each return to IDLE.
REQ-024 SHALL: the result is exact for all 2^24 operand pairs, including a_i or b_i = 0 and operands >= 3329.
REQ-025 SHALL: no arithmetic wrap is permitted anywhere; all intermediate widths are sized for the maximum P = 4095*4095.

Reset
REQ-026 SHALL: rst_i=1 immediately forces IDLE and sets busy_o=0, done_o=0, r_o=0, clears all internal registers, and clears op_cnt_o (when present).
REQ-027 SHALL: reset mid-operation aborts the operation with no done_o pulse.
REQ-028 SHALL: after reset release, the first start_i is accepted on the first rising edge.

Configuration
REQ-029 SHALL: macro MULMOD3329_OPCNT_EN defined: op_cnt_o increments by 1 on each DONE cycle, wraps from 65535 to 0, and is cleared by reset.
REQ-030 SHALL: macro MULMOD3329_OPCNT_EN undefined: the op_cnt_o port and counter logic are absent; all other behaviour and timing are identical.

Verification
REQ-031 SHALL: a=3328, b=3328 -> r_o=1, done_o exactly 17 cycles after start.
REQ-032 SHALL: a=4095, b=4095 (P=16769025) -> r_o=852; a=17, b=1000 -> r_o=355; a=0, b=4095 -> r_o=0.
REQ-033 SHALL: start pulse at cycle 0, second start at cycle 5 with different operands -> only the first result is produced, a single done_o pulse, busy_o high through cycle 17.
REQ-034 SHALL: rst_i asserted at cycle 8 of an operation -> done_o never pulses, r_o=0, busy_o=0; a new start afterwards yields a correct result.
REQ-035 SHALL: random sweep of at least 100k pairs plus all a in 0..4095 with b=4095 -> r_o matches (a*b)%3329; with MULMOD3329_OPCNT_EN, op_cnt_o equals the number of done_o pulses.
